// File: rtl/vm_param_core.sv
// vm_param_core: vending-machine controller that loads prices, takes coins and emits a buy/refund burst; VM_SOLDOUT_EN adds a per-item stock limit
module vm_param_core #(
  parameter int N_ITEMS = 6,
  parameter int PRICE_W = 5,
  parameter int COIN_W  = 6,
  parameter int MONEY_W = 9,
  parameter int NUM_W   = 6,
  parameter int RES_W   = 4,
  parameter int STOCK   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_price_valid,
  input  logic [PRICE_W-1:0] in_price,
  input  logic               in_coin_valid,
  input  logic [COIN_W-1:0]  in_coin,
  input  logic               in_refund_coin,
  input  logic [3:0]         in_buy_item,
  output logic               in_ready,
  output logic               out_valid,
  output logic [RES_W-1:0]   out_result,
  output logic [NUM_W-1:0]   out_num,
  output logic               money_sat
);
  localparam int L = N_ITEMS > 6 ? N_ITEMS : 6;
  localparam int CW = $clog2(L);
  localparam logic [MONEY_W-1:0] MMAX = '1;
`ifdef VM_SOLDOUT_EN
  localparam bit STOCK_CHK = 1'b1;
`else
  localparam bit STOCK_CHK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;
  state_t state;
  logic [PRICE_W-1:0] price [N_ITEMS];
  logic [NUM_W-1:0] sold [N_ITEMS];
  logic [MONEY_W-1:0] money;
  logic [3:0] ld_idx;
  logic [CW-1:0] cnt;
  logic [RES_W-1:0] res [6];
  logic [RES_W-1:0] res_n [6];
  logic [PRICE_W-1:0] sel_price;
  logic [NUM_W-1:0] sel_sold, sold_inc, nxt_num;
  logic [RES_W-1:0] nxt_res;
  logic [MONEY_W-1:0] bal, r1, r2, r3;
  logic [MONEY_W:0] sum;
  logic in_range, buy_ok, ok, sat_hit;
  always_comb begin
    sel_price = '0;
    sel_sold = '0;
    nxt_res = '0;
    nxt_num = '0;
    for (int i = 0; i < N_ITEMS; i++)
      if (in_buy_item == 4'(i + 1)) begin
        sel_price = price[i];
        sel_sold = sold[i];
      end
    for (int i = 0; i < 6; i++)
      if (int'(cnt) + 1 == i) nxt_res = res[i];
    for (int i = 0; i < N_ITEMS; i++)
      if (int'(cnt) + 1 == i) nxt_num = sold[i];
    in_range = in_buy_item != 4'd0 && in_buy_item <= 4'(N_ITEMS);
    buy_ok = in_range && money >= MONEY_W'(sel_price) && (!STOCK_CHK || int'(sel_sold) < STOCK);
    ok = in_refund_coin || buy_ok;
    sold_inc = &sel_sold ? sel_sold : sel_sold + 1'b1;
    // a failed buy zeroes the whole breakdown by zeroing the balance
    bal = !ok ? '0 : in_refund_coin ? money : money - MONEY_W'(sel_price);
    r1 = MONEY_W'(bal % 50);
    r2 = MONEY_W'(r1 % 20);
    r3 = MONEY_W'(r2 % 10);
    res_n[0] = (buy_ok && !in_refund_coin) ? RES_W'(in_buy_item) : '0;
    res_n[1] = RES_W'(bal / 50);
    res_n[2] = RES_W'(r1 / 20);
    res_n[3] = RES_W'(r2 / 10);
    res_n[4] = RES_W'(r3 / 5);
    res_n[5] = RES_W'(r3 % 5);
    sum = {1'b0, money} + (MONEY_W + 1)'(in_coin);
    sat_hit = sum >= {1'b0, MMAX};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      money <= '0;
      money_sat <= 1'b0;
      ld_idx <= '0;
      cnt <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_result <= '0;
      out_num <= '0;
      for (int i = 0; i < N_ITEMS; i++) begin
        price[i] <= '0;
        sold[i] <= '0;
      end
      for (int i = 0; i < 6; i++) res[i] <= '0;
    end else if (state == OUT) begin
      if (cnt == CW'(L - 1)) begin
        state <= IDLE;
        in_ready <= 1'b1;
        out_valid <= 1'b0;
        out_result <= '0;
        out_num <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        out_result <= nxt_res;
        out_num <= nxt_num;
      end
    end else if (in_price_valid) begin
      state <= LOAD;
      for (int i = 0; i < N_ITEMS; i++) begin
        if (ld_idx == 4'(i)) price[i] <= in_price;
        sold[i] <= '0;
      end
      ld_idx <= ld_idx == 4'(N_ITEMS - 1) ? ld_idx : ld_idx + 1'b1;
    end else begin
      state <= IDLE;
      ld_idx <= '0;
      if (in_coin_valid) begin
        money <= sat_hit ? MMAX : sum[MONEY_W-1:0];
        if (sat_hit) money_sat <= 1'b1;
      end else if (in_refund_coin || in_buy_item != 4'd0) begin
        state <= OUT;
        in_ready <= 1'b0;
        out_valid <= 1'b1;
        cnt <= '0;
        for (int i = 0; i < 6; i++) res[i] <= res_n[i];
        out_result <= res_n[0];
        out_num <= (buy_ok && !in_refund_coin && in_buy_item == 4'd1) ? sold_inc : sold[0];
        for (int i = 0; i < N_ITEMS; i++)
          if (buy_ok && !in_refund_coin && in_buy_item == 4'(i + 1)) sold[i] <= sold_inc;
        if (ok) begin
          money <= '0;
          money_sat <= 1'b0;
        end
      end
    end
  end
endmodule
